// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types, including instruction cache frame and state types
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Default direct-mapped instruction cache geometry: 16 one-word frames.
  localparam int ICACHE_IDX_W = 4;
  localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  typedef enum logic {
    IDLE,
    FILL
  } icache_state_t;

endpackage

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped one-word-block instruction cache; optional ICACHE_STATS_EN counters
module icache_direct
  import cpu_types_pkg::*;
#(
  parameter int NSETS = 2 ** ICACHE_IDX_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t state, next_state;
  word_t         miss_addr;
  logic [NSETS-1:0] valid;
  logic [TAG_W-1:0] tag_arr [NSETS];
  word_t            data_arr [NSETS];
  logic             flush_pend;
  logic             start_miss;
  logic             fill_done;
  logic             offset_unused;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] atag;
  logic [IDX_W-1:0] fidx;
  logic [TAG_W-1:0] ftag;

  assign idx           = imemaddr[IDX_W+1:2];
  assign atag          = imemaddr[31:IDX_W+2];
  assign fidx          = miss_addr[IDX_W+1:2];
  assign ftag          = miss_addr[31:IDX_W+2];
  assign fill_done     = (state == FILL) && !iwait;
  assign offset_unused = ^imemaddr[1:0];

  // Lookup in IDLE, hold the fill request in FILL until memory returns the word
  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    start_miss = 1'b0;
    case (state)
      IDLE: begin
        ihit = imemREN && valid[idx] && (tag_arr[idx] == atag) && !iflush;
        if (ihit) imemload = data_arr[idx];
        if (imemREN && !ihit && !iflush) begin
          start_miss = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = miss_addr;
        if (!iwait) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State, miss address and valid bits; a flush seen at any point of a fill leaves that frame invalid
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      miss_addr  <= '0;
      valid      <= '0;
      flush_pend <= 1'b0;
    end else begin
      state <= next_state;
      if (start_miss) miss_addr <= {imemaddr[31:2], 2'b00};
      if (iflush) valid <= '0;
      if (fill_done) valid[fidx] <= !(iflush || flush_pend);
      if (fill_done) flush_pend <= 1'b0;
      else if (state == FILL && iflush) flush_pend <= 1'b1;
    end
  end

  // Tag and data arrays are qualified by valid, so they carry no reset
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_arr[fidx]  <= ftag;
      data_arr[fidx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  // Free-running hit and miss counters, wrapping at 2^32
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit) hit_count <= hit_count + 32'd1;
      if (start_miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - scoreboard testbench for icache_direct
module tb_icache_direct;

  logic        CLK, RST, imemREN, iflush, iwait;
  logic [31:0] imemaddr, iload;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
  logic [31:0] hc;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mem [64];
  logic [31:0] exp_q [$];
  logic [31:0] expv;

  icache_direct dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .iflush(iflush),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task step;
    @(posedge CLK);
    #1;
  endtask

  // Memory side: hold iwait high for some cycles, then return the word at the requested address
  task serve(input int waits);
    repeat (waits) begin
      iwait = 1'b1;
      step();
    end
    iwait = 1'b0;
    iload = mem[iaddr[7:2]];
    step();
    iwait = 1'b1;
    iload = '0;
  endtask

  task test_reset;
    RST = 1'b1; imemREN = 1'b0; iflush = 1'b0; iwait = 1'b1; iload = '0; imemaddr = '0;
    repeat (2) step();
    RST = 1'b0;
    #1;
    n_cmp++; if (ihit !== 1'b0) begin n_bad++; $display("FAIL reset_ihit: got %b expected 0", ihit); end
    n_cmp++; if (imemload !== 32'h0) begin n_bad++; $display("FAIL reset_imemload: got %h expected 0", imemload); end
    n_cmp++; if (iREN !== 1'b0) begin n_bad++; $display("FAIL reset_iREN: got %b expected 0", iREN); end
    n_cmp++; if (iaddr !== 32'h0) begin n_bad++; $display("FAIL reset_iaddr: got %h expected 0", iaddr); end
  endtask

  task test_miss_fill;
    imemREN = 1'b1; imemaddr = 32'h0; #1;
    n_cmp++; if (ihit !== 1'b0) begin n_bad++; $display("FAIL cold_miss_ihit: got %b expected 0", ihit); end
    step();
    n_cmp++; if (iREN !== 1'b1) begin n_bad++; $display("FAIL fill_iREN: got %b expected 1", iREN); end
    n_cmp++; if (iaddr !== 32'h0) begin n_bad++; $display("FAIL fill_iaddr: got %h expected 0", iaddr); end
    exp_q.push_back(32'h2008_0004);
    serve(1);
    expv = exp_q.pop_front();
    n_cmp++; if (ihit !== 1'b1) begin n_bad++; $display("FAIL fill_then_hit: got %b expected 1", ihit); end
    n_cmp++; if (imemload !== expv) begin n_bad++; $display("FAIL fill_data: got %h expected %h", imemload, expv); end
`ifdef ICACHE_STATS_EN
    n_cmp++; if (miss_count !== 32'd1) begin n_bad++; $display("FAIL miss_count: got %0d expected 1", miss_count); end
`endif
  endtask

  task test_hit;
    exp_q.push_back(mem[0]);
`ifdef ICACHE_STATS_EN
    hc = hit_count;
`endif
    expv = exp_q.pop_front();
    n_cmp++; if (ihit !== 1'b1) begin n_bad++; $display("FAIL rehit_ihit: got %b expected 1", ihit); end
    n_cmp++; if (iREN !== 1'b0) begin n_bad++; $display("FAIL rehit_iREN: got %b expected 0", iREN); end
    n_cmp++; if (imemload !== expv) begin n_bad++; $display("FAIL rehit_data: got %h expected %h", imemload, expv); end
    step();
`ifdef ICACHE_STATS_EN
    n_cmp++; if (hit_count !== hc + 32'd1) begin n_bad++; $display("FAIL hit_count: got %0d expected %0d", hit_count, hc + 32'd1); end
`endif
  endtask

  task test_conflict;
    imemaddr = 32'h40; #1;
    n_cmp++; if (ihit !== 1'b0) begin n_bad++; $display("FAIL conflict_miss: got %b expected 0", ihit); end
    step();
    n_cmp++; if (iaddr !== 32'h40) begin n_bad++; $display("FAIL conflict_iaddr: got %h expected 00000040", iaddr); end
    exp_q.push_back(mem[16]);
    serve(0);
    expv = exp_q.pop_front();
    n_cmp++; if (ihit !== 1'b1 || imemload !== expv) begin n_bad++; $display("FAIL conflict_hit: got %b/%h expected 1/%h", ihit, imemload, expv); end
    imemaddr = 32'h0; #1;
    n_cmp++; if (ihit !== 1'b0) begin n_bad++; $display("FAIL replaced_miss: got %b expected 0", ihit); end
    step();
    n_cmp++; if (iREN !== 1'b1) begin n_bad++; $display("FAIL replaced_iREN: got %b expected 1", iREN); end
    exp_q.push_back(mem[0]);
    serve(0);
    expv = exp_q.pop_front();
    n_cmp++; if (ihit !== 1'b1 || imemload !== expv) begin n_bad++; $display("FAIL refill_hit: got %b/%h expected 1/%h", ihit, imemload, expv); end
  endtask

  task test_midfill;
    imemaddr = 32'h4; #1;
    step();
    imemaddr = 32'h8; iwait = 1'b1; #1;
    n_cmp++; if (iaddr !== 32'h4) begin n_bad++; $display("FAIL midfill_iaddr0: got %h expected 00000004", iaddr); end
    step();
    n_cmp++; if (iaddr !== 32'h4 || iREN !== 1'b1) begin n_bad++; $display("FAIL midfill_iaddr1: got %h/%b expected 00000004/1", iaddr, iREN); end
    serve(0);
    n_cmp++; if (ihit !== 1'b0) begin n_bad++; $display("FAIL newaddr_miss: got %b expected 0", ihit); end
    step();
    n_cmp++; if (iaddr !== 32'h8) begin n_bad++; $display("FAIL newaddr_iaddr: got %h expected 00000008", iaddr); end
    exp_q.push_back(mem[2]);
    serve(0);
    expv = exp_q.pop_front();
    n_cmp++; if (ihit !== 1'b1 || imemload !== expv) begin n_bad++; $display("FAIL newaddr_hit: got %b/%h expected 1/%h", ihit, imemload, expv); end
    imemaddr = 32'h4; #1;
    exp_q.push_back(mem[1]);
    expv = exp_q.pop_front();
    n_cmp++; if (ihit !== 1'b1 || imemload !== expv) begin n_bad++; $display("FAIL oldaddr_hit: got %b/%h expected 1/%h", ihit, imemload, expv); end
  endtask

  task test_flush;
    imemaddr = 32'hC; #1;
    step();
    n_cmp++; if (iaddr !== 32'hC) begin n_bad++; $display("FAIL flushfill_iaddr: got %h expected 0000000c", iaddr); end
    iwait = 1'b0; iload = mem[3]; iflush = 1'b1;
    step();
    iflush = 1'b0; iwait = 1'b1; iload = '0; #1;
    n_cmp++; if (ihit !== 1'b0) begin n_bad++; $display("FAIL flushfill_invalid: got %b expected 0", ihit); end
    step();
    n_cmp++; if (iREN !== 1'b1 || iaddr !== 32'hC) begin n_bad++; $display("FAIL flushfill_refetch: got %b/%h expected 1/0000000c", iREN, iaddr); end
    exp_q.push_back(mem[3]);
    serve(0);
    expv = exp_q.pop_front();
    n_cmp++; if (ihit !== 1'b1 || imemload !== expv) begin n_bad++; $display("FAIL flushfill_hit: got %b/%h expected 1/%h", ihit, imemload, expv); end
    iflush = 1'b1; #1;
    n_cmp++; if (ihit !== 1'b0) begin n_bad++; $display("FAIL idleflush_ihit: got %b expected 0", ihit); end
    step();
    iflush = 1'b0; #1;
    n_cmp++; if (iREN !== 1'b0) begin n_bad++; $display("FAIL idleflush_nomiss: got %b expected 0", iREN); end
    n_cmp++; if (ihit !== 1'b0) begin n_bad++; $display("FAIL idleflush_cleared: got %b expected 0", ihit); end
    step();
    exp_q.push_back(mem[3]);
    serve(0);
    expv = exp_q.pop_front();
    n_cmp++; if (ihit !== 1'b1 || imemload !== expv) begin n_bad++; $display("FAIL idleflush_refill: got %b/%h expected 1/%h", ihit, imemload, expv); end
  endtask

  task test_reset_fill;
    imemaddr = 32'h0; #1;
    step();
    exp_q.push_back(mem[0]);
    serve(0);
    expv = exp_q.pop_front();
    n_cmp++; if (ihit !== 1'b1 || imemload !== expv) begin n_bad++; $display("FAIL prereset_hit: got %b/%h expected 1/%h", ihit, imemload, expv); end
    imemaddr = 32'h10; #1;
    step();
    n_cmp++; if (iREN !== 1'b1) begin n_bad++; $display("FAIL prereset_fill: got %b expected 1", iREN); end
    RST = 1'b1;
    step();
    RST = 1'b0; #1;
    n_cmp++; if (iREN !== 1'b0 || ihit !== 1'b0 || imemload !== 32'h0) begin n_bad++; $display("FAIL midfill_reset: got %b/%b/%h expected 0/0/00000000", iREN, ihit, imemload); end
    imemaddr = 32'h0; #1;
    n_cmp++; if (ihit !== 1'b0) begin n_bad++; $display("FAIL postreset_miss: got %b expected 0", ihit); end
`ifdef ICACHE_STATS_EN
    n_cmp++; if (miss_count !== 32'd0) begin n_bad++; $display("FAIL postreset_miss_count: got %0d expected 0", miss_count); end
`endif
    step();
    n_cmp++; if (iREN !== 1'b1 || iaddr !== 32'h0) begin n_bad++; $display("FAIL postreset_fill: got %b/%h expected 1/00000000", iREN, iaddr); end
    exp_q.push_back(mem[0]);
    serve(0);
    expv = exp_q.pop_front();
    n_cmp++; if (ihit !== 1'b1 || imemload !== expv) begin n_bad++; $display("FAIL postreset_hit: got %b/%h expected 1/%h", ihit, imemload, expv); end
    imemREN = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0011);
    mem[0] = 32'h2008_0004;
    test_reset();
    test_miss_fill();
    test_hit();
    test_conflict();
    test_midfill();
    test_flush();
    test_reset_fill();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
